ahb_apb_bridge_gen2: RTL and testbench
======================================

AHB_APB_BRIDGE_GEN2 -- requirements
Module: ahb_apb_bridge_gen2

Interface
REQ-001 SHALL have parameter AW, 32, address width of Haddr and Paddr.
REQ-002 SHALL have parameter DW, 32, data width of Hwdata/Hrdata/Pwdata/Prdata; legal values 8, 16, 32 or 64.
REQ-003 SHALL have parameter NSLV, 4, number of APB slaves (Psel width); legal range 1..16.
REQ-004 SHALL have parameter DEC_LSB, 12, lowest Haddr bit of the slave index field Haddr[DEC_LSB +: clog2(NSLV)].
REQ-005 SHALL have ports Hclk in 1 clock; Hresetn in 1 reset (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have ports Hsel in 1 bridge select; Haddr in AW; Htrans in 2; Hwrite in 1; Hsize in 3; Hburst in 3; Hwdata in DW.
REQ-007 SHALL have ports Hready out 1; Hresp out 1 (1 = ERROR); Hrdata out DW.
REQ-008 SHALL have ports Paddr out AW; Psel out NSLV (one-hot); Penable out 1; Pwrite out 1; Pwdata out DW; Pstrb out DW/8; Prdata in DW; Pready in 1; Pslverr in 1.

Function
REQ-009 SHALL accept a transfer in IDLE when Hsel=1, Htrans is NONSEQ(2'b10) or SEQ(2'b11), and Hready=1; Htrans IDLE/BUSY and Hsel=0 SHALL start no APB access.
REQ-010 SHALL treat every accepted beat, including INCR/WRAP bursts, as an independent APB transfer; Hburst is ignored.
REQ-011 SHALL use FSM states IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
REQ-012 SHALL transition IDLE->WDATA for an accepted write and IDLE->SETUP for an accepted read, registering Haddr, Hwrite, Hsize and the slave index.
REQ-013 SHALL register Hwdata into Pwdata in WDATA, then go to SETUP.
REQ-014 SHALL drive, in SETUP, the decoded Psel bit=1 and Penable=0, then go to ACCESS.
REQ-015 SHALL drive, in ACCESS, Psel and Penable=1 and hold Paddr/Pwrite/Pwdata/Pstrb stable until Pready=1; no timeout applies.
REQ-016 SHALL, in ACCESS with Pready=1 and no error, register Prdata into Hrdata for a read and return to IDLE.
REQ-017 SHALL drive Hready=1 only in IDLE and ERR2.
REQ-018 SHALL give read latency from the address-phase cycle A of: SETUP A+1, ACCESS A+2, Hready=1 with Hrdata valid at A+3 for zero APB wait states; a write adds one cycle.
REQ-019 SHALL, for a transfer accepted in the same IDLE cycle that completes a previous one, start the new access with no extra idle cycle.
REQ-020 SHALL set Pstrb for writes from Hsize and Haddr low bits: byte=1 lane, half=2 aligned lanes, word=4 lanes, dword=8 lanes; Pstrb SHALL be all-zero for reads.
REQ-021 SHALL treat an Hsize wider than DW/8 bytes as a decode error.
REQ-022 SHALL treat a slave index >= NSLV as a decode error.
REQ-023 SHALL hold Hrdata at its last value except when a read completes.

Reset
REQ-024 SHALL on Hresetn=0, immediately and asynchronously, force state=IDLE, Psel=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Pstrb=0, Hrdata=0, Hready=1 and Hresp=0, including mid-ACCESS.
REQ-025 SHALL, after reset release, accept a transfer on the first rising Hclk edge.

Configuration
REQ-026 SHALL, with AHB_APB_ERR_EN defined, route Pslverr=1 in ACCESS with Pready=1, and any decode error from IDLE, to ERR1 (Hready=0, Hresp=1), then ERR2 (Hready=1, Hresp=1), then IDLE; decode errors SHALL assert no Psel.
REQ-027 SHALL, without AHB_APB_ERR_EN, tie Hresp to 0 and ignore Pslverr.
REQ-028 SHALL, without AHB_APB_ERR_EN, complete a decode-error transfer via ERR1 then IDLE with Hresp=0, without asserting Psel; such reads return Hrdata=0 and such writes are dropped.

Structure
REQ-029 SHALL define in package ahb_apb_pkg the Htrans and Hsize encodings, the FSM state enum and the index width function.
REQ-030 SHALL implement Pstrb generation and the Hsize legality check in sub-module apb_strb_gen.

Verification
REQ-031 SHALL cover: read of 0x0000_1004, Prdata=0xDEAD_BEEF, Pready=1 -> Psel=4'b0010, Hready=1 and Hrdata=0xDEAD_BEEF at A+3.
REQ-032 SHALL cover: byte write to 0x0000_2003 with data 0xAA00_0000 and Pready low for 3 cycles -> Pstrb=4'b1000 and Pwrite=1 throughout ACCESS; Hready=1 at A+7.
REQ-033 SHALL cover: 4-beat INCR write at 0x0000_3000 -> four SETUP/ACCESS pairs on Psel=4'b1000 with Paddr 0x3000, 0x3004, 0x3008, 0x300C.
REQ-034 SHALL cover: Pslverr=1 on a read, with the macro defined -> Hresp=1 for 2 cycles and Hready pattern 0,1.
REQ-035 SHALL cover: Haddr=0x0000_5000 with NSLV=4 -> no Psel asserted; ERROR response with the macro, OKAY with Hrdata=0 without it.
REQ-036 SHALL cover: Hresetn=0 asserted mid-ACCESS -> Psel=0, Penable=0, Hready=1 before the next Hclk edge.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared encodings, FSM states and index helper for ahb_apb_bridge_gen2.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  // A single slave still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// rtl/apb_strb_gen.sv - write lane strobes from Hsize/Haddr and Hsize legality check.
module apb_strb_gen #(
  parameter int DW = 32
) (
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      size,
  input  logic            write,
  output logic [DW/8-1:0] strb,
  output logic            size_err
);

  localparam int NB = DW / 8;
  localparam int LB = (NB > 1) ? $clog2(NB) : 0;

  int lane_base;

  // A lane is enabled when it falls in the same size-aligned block as the address.
  always_comb begin
    size_err  = (int'(size) > LB);
    lane_base = int'(addr_lo) & (NB - 1);
    strb      = '0;
    for (int i = 0; i < NB; i++) begin
      strb[i] = write && !size_err && ((i >> size) == (lane_base >> size));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_gen2.sv
// rtl/ahb_apb_bridge_gen2.sv - AHB to APB bridge, one APB access per AHB beat.
// Optional error responses (Pslverr, decode errors) enabled by AHB_APB_ERR_EN.
module ahb_apb_bridge_gen2
  import ahb_apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int DEC_LSB = 12
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic            Hsel,
  input  logic [AW-1:0]   Haddr,
  input  logic [1:0]      Htrans,
  input  logic            Hwrite,
  input  logic [2:0]      Hsize,
  input  logic [2:0]      Hburst,
  input  logic [DW-1:0]   Hwdata,
  output logic            Hready,
  output logic            Hresp,
  output logic [DW-1:0]   Hrdata,
  output logic [AW-1:0]   Paddr,
  output logic [NSLV-1:0] Psel,
  output logic            Penable,
  output logic            Pwrite,
  output logic [DW-1:0]   Pwdata,
  output logic [DW/8-1:0] Pstrb,
  input  logic [DW-1:0]   Prdata,
  input  logic            Pready,
  input  logic            Pslverr
);

  localparam int IW = idx_width(NSLV);
  localparam int UW = AW - DEC_LSB;

  state_t          state, state_nx;
  logic [IW-1:0]   slv_idx;
  logic [DW/8-1:0] strb_nx;
  logic            accept, size_err, idx_err, dec_err, slv_err;
  logic            unused_bits;

  apb_strb_gen #(.DW(DW)) u_strb (
    .addr_lo  (Haddr[2:0]),
    .size     (Hsize),
    .write    (Hwrite),
    .strb     (strb_nx),
    .size_err (size_err)
  );

  // Every address bit above DEC_LSB takes part, so holes past NSLV are errors.
  assign idx_err = (Haddr[AW-1:DEC_LSB] >= UW'(NSLV));
  assign dec_err = idx_err || size_err;
  assign accept  = (state == IDLE) && Hsel && Htrans[1];

`ifdef AHB_APB_ERR_EN
  assign slv_err     = Pslverr;
  assign unused_bits = ^{Hburst, Htrans[0]};
`else
  assign slv_err     = 1'b0;
  assign unused_bits = ^{Hburst, Htrans[0], Pslverr};
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_err)     state_nx = ERR1;
          else if (Hwrite) state_nx = WDATA;
          else             state_nx = SETUP;
        end
      end
      WDATA:  state_nx = SETUP;
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        if (Pready) state_nx = slv_err ? ERR1 : IDLE;
      end
`ifdef AHB_APB_ERR_EN
      ERR1:   state_nx = ERR2;
`else
      ERR1:   state_nx = IDLE;
`endif
      ERR2:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Hready  = (state == IDLE) || (state == ERR2);
    Penable = (state == ACCESS);
`ifdef AHB_APB_ERR_EN
    Hresp   = (state == ERR1) || (state == ERR2);
`else
    Hresp   = 1'b0;
`endif
    Psel = '0;
    for (int i = 0; i < NSLV; i++) begin
      Psel[i] = ((state == SETUP) || (state == ACCESS)) && (slv_idx == IW'(i));
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state   <= IDLE;
      slv_idx <= '0;
      Paddr   <= '0;
      Pwrite  <= 1'b0;
      Pwdata  <= '0;
      Pstrb   <= '0;
      Hrdata  <= '0;
    end else begin
      state <= state_nx;
      // Pwrite also remembers the direction of a decode-error beat.
      if (accept) begin
        Pwrite <= Hwrite;
      end
      if (accept && !dec_err) begin
        Paddr   <= Haddr;
        Pstrb   <= strb_nx;
        slv_idx <= Haddr[DEC_LSB +: IW];
      end
      if (state == WDATA) begin
        Pwdata <= Hwdata;
      end
      if ((state == ACCESS) && Pready && !Pwrite && !slv_err) begin
        Hrdata <= Prdata;
      end
`ifndef AHB_APB_ERR_EN
      if ((state == ERR1) && !Pwrite) begin
        Hrdata <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// tb/tb_ahb_apb_bridge_gen2.sv - directed self-checking bench for ahb_apb_bridge_gen2.
module tb_ahb_apb_bridge_gen2;

  logic        Hclk;
  logic        Hresetn;
  logic        Hsel;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] Hwdata;
  logic        Hready;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Paddr;
  logic [3:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic [3:0]  Pstrb;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_apb_bridge_gen2 #(.AW(32), .DW(32), .NSLV(4), .DEC_LSB(12)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .Hsel    (Hsel),
    .Haddr   (Haddr),
    .Htrans  (Htrans),
    .Hwrite  (Hwrite),
    .Hsize   (Hsize),
    .Hburst  (Hburst),
    .Hwdata  (Hwdata),
    .Hready  (Hready),
    .Hresp   (Hresp),
    .Hrdata  (Hrdata),
    .Paddr   (Paddr),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Pwdata  (Pwdata),
    .Pstrb   (Pstrb),
    .Prdata  (Prdata),
    .Pready  (Pready),
    .Pslverr (Pslverr)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Hclk);
    #1;
  endtask

  task automatic neg();
    @(negedge Hclk);
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] s);
    Hsel   = 1'b1;
    Haddr  = a;
    Htrans = t;
    Hwrite = w;
    Hsize  = s;
  endtask

  task automatic bus_idle();
    Hsel   = 1'b0;
    Htrans = 2'b00;
  endtask

  initial begin
    Hresetn = 1'b0; Hsel = 1'b0; Haddr = '0; Htrans = 2'b00; Hwrite = 1'b0;
    Hsize = 3'd0; Hburst = 3'd0; Hwdata = '0; Prdata = '0; Pready = 1'b1; Pslverr = 1'b0;

    #2;
    check("rst_psel", Psel, 4'b0000);
    check("rst_penable", Penable, 1'b0);
    check("rst_hready", Hready, 1'b1);
    check("rst_hresp", Hresp, 1'b0);
    check("rst_hrdata", Hrdata, 32'h0);
    check("rst_paddr", Paddr, 32'h0);
    check("rst_pstrb", Pstrb, 4'h0);
    @(posedge Hclk);
    @(posedge Hclk);
    #1;
    Hresetn = 1'b1;

    // read 0x1004, zero wait states
    addr_phase(32'h0000_1004, 2'b10, 1'b0, 3'd2);
    Prdata = 32'hDEAD_BEEF;
    neg(); check("rd_a_hready", Hready, 1'b1);
    cyc(); bus_idle();
    neg(); check("rd_setup_psel", Psel, 4'b0010);
    check("rd_setup_penable", Penable, 1'b0);
    check("rd_pstrb", Pstrb, 4'b0000);
    check("rd_paddr", Paddr, 32'h0000_1004);
    cyc();
    neg(); check("rd_access_psel", Psel, 4'b0010);
    check("rd_access_penable", Penable, 1'b1);
    check("rd_access_hready", Hready, 1'b0);
    cyc();
    neg(); check("rd_a3_hready", Hready, 1'b1);
    check("rd_a3_hrdata", Hrdata, 32'hDEAD_BEEF);
    check("rd_a3_psel", Psel, 4'b0000);

    // Hsel=0 and BUSY start nothing
    cyc(); Hsel = 1'b0; Htrans = 2'b10; Haddr = 32'h0000_1000;
    cyc();
    neg(); check("nosel_psel", Psel, 4'b0000);
    check("nosel_hready", Hready, 1'b1);
    cyc(); Hsel = 1'b1; Htrans = 2'b01;
    cyc();
    neg(); check("busy_psel", Psel, 4'b0000);
    check("busy_hready", Hready, 1'b1);

    // byte write 0x2003 with three APB wait states
    cyc(); addr_phase(32'h0000_2003, 2'b10, 1'b1, 3'd0);
    cyc(); Hwdata = 32'hAA00_0000; bus_idle(); Pready = 1'b0;
    neg(); check("bw_wdata_hready", Hready, 1'b0);
    check("bw_wdata_psel", Psel, 4'b0000);
    cyc();
    neg(); check("bw_setup_psel", Psel, 4'b0100);
    check("bw_setup_penable", Penable, 1'b0);
    check("bw_setup_pstrb", Pstrb, 4'b1000);
    check("bw_setup_pwdata", Pwdata, 32'hAA00_0000);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) Pready = 1'b1;
      neg(); check("bw_access_penable", Penable, 1'b1);
      check("bw_access_pwrite", Pwrite, 1'b1);
      check("bw_access_pstrb", Pstrb, 4'b1000);
      check("bw_access_hready", Hready, 1'b0);
    end
    cyc();
    neg(); check("bw_a7_hready", Hready, 1'b1);
    check("bw_a7_psel", Psel, 4'b0000);

    // halfword write to upper half
    cyc(); addr_phase(32'h0000_1002, 2'b10, 1'b1, 3'd1);
    cyc(); Hwdata = 32'h1234_0000; bus_idle();
    cyc();
    neg(); check("hw_pstrb", Pstrb, 4'b1100);
    check("hw_psel", Psel, 4'b0010);
    cyc();
    cyc();
    neg(); check("hw_hready", Hready, 1'b1);

    // 4-beat INCR write, back-to-back beats
    cyc(); addr_phase(32'h0000_3000, 2'b10, 1'b1, 3'd2); Hburst = 3'b011;
    for (int b = 0; b < 4; b++) begin
      cyc();
      Hwdata = 32'h1000_0000 + 32'(b);
      if (b < 3) addr_phase(32'h0000_3000 + 32'(4 * (b + 1)), 2'b11, 1'b1, 3'd2);
      else bus_idle();
      cyc();
      neg(); check("burst_setup_psel", Psel, 4'b1000);
      check("burst_setup_penable", Penable, 1'b0);
      check("burst_paddr", Paddr, 32'h0000_3000 + 32'(4 * b));
      check("burst_pwdata", Pwdata, 32'h1000_0000 + 32'(b));
      check("burst_pstrb", Pstrb, 4'b1111);
      cyc();
      neg(); check("burst_access_penable", Penable, 1'b1);
      cyc();
      neg(); check("burst_idle_hready", Hready, 1'b1);
    end
    Hburst = 3'b000;

    // dword on 32-bit bus is a decode error
    cyc(); addr_phase(32'h0000_1000, 2'b10, 1'b1, 3'd3);
    cyc(); bus_idle();
    neg(); check("sz_err1_psel", Psel, 4'b0000);
    check("sz_err1_hready", Hready, 1'b0);
`ifdef AHB_APB_ERR_EN
    check("sz_err1_hresp", Hresp, 1'b1);
    cyc();
    neg(); check("sz_err2_hready", Hready, 1'b1);
    check("sz_err2_hresp", Hresp, 1'b1);
`endif
    cyc();
    neg(); check("sz_done_hready", Hready, 1'b1);
    check("sz_done_hresp", Hresp, 1'b0);
    check("sz_done_psel", Psel, 4'b0000);

    // out-of-range slave index read at 0x5000
    cyc(); addr_phase(32'h0000_5000, 2'b10, 1'b0, 3'd2);
    cyc(); bus_idle();
    neg(); check("dec_err1_psel", Psel, 4'b0000);
    check("dec_err1_hready", Hready, 1'b0);
`ifdef AHB_APB_ERR_EN
    check("dec_err1_hresp", Hresp, 1'b1);
    cyc();
    neg(); check("dec_err2_hready", Hready, 1'b1);
    check("dec_err2_hresp", Hresp, 1'b1);
    check("dec_err2_psel", Psel, 4'b0000);
    cyc();
    neg(); check("dec_done_hresp", Hresp, 1'b0);
`else
    check("dec_err1_hresp", Hresp, 1'b0);
    cyc();
    neg(); check("dec_done_hready", Hready, 1'b1);
    check("dec_done_hresp", Hresp, 1'b0);
    check("dec_done_hrdata", Hrdata, 32'h0);
    check("dec_done_psel", Psel, 4'b0000);
`endif

    // Pslverr on a read
    cyc(); addr_phase(32'h0000_1004, 2'b10, 1'b0, 3'd2); Prdata = 32'h0BAD_F00D;
    cyc(); bus_idle(); Pslverr = 1'b1;
    cyc();
    neg(); check("slverr_access_penable", Penable, 1'b1);
`ifdef AHB_APB_ERR_EN
    cyc();
    neg(); check("slverr_e1_hready", Hready, 1'b0);
    check("slverr_e1_hresp", Hresp, 1'b1);
    check("slverr_e1_psel", Psel, 4'b0000);
    cyc(); Pslverr = 1'b0;
    neg(); check("slverr_e2_hready", Hready, 1'b1);
    check("slverr_e2_hresp", Hresp, 1'b1);
    cyc();
    neg(); check("slverr_idle_hresp", Hresp, 1'b0);
    check("slverr_idle_hready", Hready, 1'b1);
`else
    cyc(); Pslverr = 1'b0;
    neg(); check("slverr_ign_hready", Hready, 1'b1);
    check("slverr_ign_hresp", Hresp, 1'b0);
    check("slverr_ign_hrdata", Hrdata, 32'h0BAD_F00D);
`endif

    // asynchronous reset in the middle of ACCESS
    cyc(); addr_phase(32'h0000_1004, 2'b10, 1'b0, 3'd2); Pready = 1'b0;
    cyc(); bus_idle();
    cyc();
    neg(); check("mid_access_penable", Penable, 1'b1);
    check("mid_access_psel", Psel, 4'b0010);
    Hresetn = 1'b0;
    #1;
    check("arst_psel", Psel, 4'b0000);
    check("arst_penable", Penable, 1'b0);
    check("arst_hready", Hready, 1'b1);
    check("arst_hresp", Hresp, 1'b0);
    check("arst_paddr", Paddr, 32'h0);
    check("arst_hrdata", Hrdata, 32'h0);
    check("arst_pwdata", Pwdata, 32'h0);
    check("arst_pstrb", Pstrb, 4'h0);
    cyc(); Hresetn = 1'b1; Pready = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
